edge_threshold: RTL
===================

EDGE_THRESHOLD -- requirements
Module: edge_threshold

Interface
REQ-001 The block SHALL have parameter linewidth_px_p, default 16, meaning pixels per line.
REQ-002 The block SHALL have parameter frame_height_p, default 16, meaning lines per frame.
REQ-003 The block SHALL have parameter in_width_p, default 32, meaning signed gradient width.
REQ-004 The block SHALL have parameter kernel_width_p, default 3, meaning upstream kernel size used for border suppression.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 The block SHALL have port reset_i, input, 1 bit: synchronous, active-low reset (reset when 0).
REQ-007 The block SHALL have port valid_i, input, 1 bit: gx_i/gy_i valid.
REQ-008 The block SHALL have port ready_o, output, 1 bit: block can accept.
REQ-009 The block SHALL have port gx_i, input, signed in_width_p bits: horizontal gradient.
REQ-010 The block SHALL have port gy_i, input, signed in_width_p bits: vertical gradient.
REQ-011 The block SHALL have port threshold_i, input, unsigned in_width_p+1 bits: edge threshold.
REQ-012 The block SHALL have port valid_o, output, 1 bit: output valid.
REQ-013 The block SHALL have port ready_i, input, 1 bit: downstream can accept.
REQ-014 The block SHALL have port mag_o, output, unsigned in_width_p+1 bits: |gx|+|gy|, or 0 at border.
REQ-015 The block SHALL have port edge_o, output, 1 bit: edge decision.
REQ-016 The block SHALL have port eol_o, output, 1 bit: last pixel of line.
REQ-017 The block SHALL have port eof_o, output, 1 bit: last pixel of frame.

Function
REQ-018 The block SHALL accept an input on a cycle where valid_i & ready_o.
REQ-019 The block SHALL be a two-stage elastic pipeline:
- S1 registers |gx|, |gy|, border flag, eol, eof.
- S2 registers mag, edge, eol, eof.
REQ-020 Each stage SHALL load when it is empty or its contents advance in the same cycle.
REQ-021 ready_o SHALL equal ~s1_valid | s2_ready_w, where s2_ready_w = ~valid_o | ready_i.
REQ-022 Latency SHALL be 2 cycles from acceptance to valid_o when not stalled; throughput SHALL be 1 pixel per cycle with ready_i held high.
REQ-023 valid_o and all data outputs SHALL remain stable while valid_o & ~ready_i.
REQ-024 Absolute value SHALL be computed at in_width_p+1 bits, so |most-negative| is exact (for example, in_width_p=8: |-128| = 128); the sum SHALL be computed at in_width_p+1 bits, with no saturation needed given upstream ranges.
REQ-025 edge_o SHALL equal (mag >= thr_r) & ~border.
REQ-026 mag_o SHALL be forced to 0 when border is set.
REQ-027 Column counter col_r SHALL count 0..linewidth_px_p-1 and advance on each acceptance.
REQ-028 Row counter row_r SHALL count 0..frame_height_p-1 and advance when col_r wraps.
REQ-029 Both counters SHALL wrap to 0 after the last pixel of the frame.
REQ-030 border SHALL be set when row_r < kernel_width_p-1 or col_r < kernel_width_p-1, evaluated on the accepted pixel's coordinates.
REQ-031 eol SHALL be set when col_r == linewidth_px_p-1; eof SHALL be set when eol and row_r == frame_height_p-1.
REQ-032 Threshold latch thr_r SHALL capture threshold_i only when the accepted pixel is at col_r==0 and row_r==0; threshold_i changes mid-frame SHALL NOT affect the current frame.
REQ-033 A simultaneous S2 drain and S1 load SHALL lose no data and duplicate no data.

Reset
REQ-034 While reset_i==0 at a clock edge, s1_valid, valid_o, col_r and row_r SHALL clear to 0.
REQ-035 While reset_i==0 at a clock edge, mag_o, edge_o, eol_o and eof_o SHALL clear to 0, and thr_r SHALL clear to all-ones (no edges until first frame start).
REQ-036 A reset mid-frame SHALL discard in-flight pixels, and the next accepted pixel SHALL be treated as (row 0, col 0).
REQ-037 ready_o SHALL be 1 on the first cycle after reset deasserts.

Structure
REQ-038 The width helpers (magnitude width = in_width_p+1) and the border-extent constant SHALL live in the shared vision package.
REQ-039 One sub-module, abs_val (signed in, unsigned in_width_p+1 out, combinational), SHALL be instantiated twice.
REQ-040 Counters and the threshold latch SHALL remain in the top module.

Verification
REQ-041 Bench scenario: in_width_p=8, threshold 10 at frame start, gx=-6 and gy=5 at interior (row 2, col 2) -> 2 cycles later mag_o=11, edge_o=1.
REQ-042 Bench scenario: gx=-128, gy=-128 interior, threshold 300 -> mag_o=256, edge_o=0; with threshold 256 -> edge_o=1.
REQ-043 Bench scenario: full 16x16 frame of gx=50, gy=0, threshold 1 -> edge_o=0 for rows 0-1 and cols 0-1, 1 elsewhere; eol_o on every 16th output; eof_o on output 256 only; second frame repeats the pattern.
REQ-044 Bench scenario: ready_i low for 5 cycles with valid_i continuous -> ready_o falls after 2 pixels are buffered, outputs are held stable, and no pixel is lost or duplicated on release.
REQ-045 Bench scenario: threshold_i changed from 10 to 100 at pixel (5,5) -> current-frame decisions still use 10, and the next frame uses 100.
REQ-046 Bench scenario: reset_i=0 asserted mid-line at col 7 -> valid_o=0 next cycle, and the first post-reset pixel is treated as a border pixel at (0,0).

Source files
------------

// File: rtl/edge_threshold_pkg.sv
// Shared vision helpers: magnitude width, border extent and counter sizing.
package edge_threshold_pkg;

  typedef struct packed {
    logic border;
    logic eol;
    logic eof;
  } px_flags_t;

  // |gx|+|gy| needs one bit more than the signed gradient so |most-negative| is exact.
  function automatic int mag_width(input int in_width);
    return in_width + 1;
  endfunction

  function automatic int border_extent(input int kernel_width);
    return kernel_width - 1;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/abs_val.sv
// Combinational absolute value of a signed operand, widened by one bit.
module abs_val
  import edge_threshold_pkg::*;
#(
  parameter int in_width_p = 32
) (
  input  logic signed [in_width_p-1:0]            val_i,
  output logic        [mag_width(in_width_p)-1:0] abs_o
);

  logic signed [in_width_p:0] ext_w;

  assign ext_w = {val_i[in_width_p-1], val_i};
  assign abs_o = ext_w[in_width_p] ? $unsigned(-ext_w) : $unsigned(ext_w);

endmodule

// File: rtl/edge_threshold.sv
// Gradient magnitude + threshold with kernel-border suppression and line/frame markers.
// Two-stage elastic pipeline, 2-cycle latency, full throughput; stages hold under ready_i low.
module edge_threshold
  import edge_threshold_pkg::*;
#(
  parameter int linewidth_px_p = 16,
  parameter int frame_height_p = 16,
  parameter int in_width_p     = 32,
  parameter int kernel_width_p = 3
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic signed [in_width_p-1:0] gx_i,
  input  logic signed [in_width_p-1:0] gy_i,
  input  logic        [in_width_p:0]   threshold_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic        [in_width_p:0]   mag_o,
  output logic                         edge_o,
  output logic                         eol_o,
  output logic                         eof_o
);

  localparam int MW = mag_width(in_width_p);
  localparam int BX = border_extent(kernel_width_p);
  localparam int CW = cnt_width(linewidth_px_p);
  localparam int RW = cnt_width(frame_height_p);

  logic [MW-1:0] abs_gx_w;
  logic [MW-1:0] abs_gy_w;

  abs_val #(.in_width_p(in_width_p)) u_abs_gx (
    .val_i (gx_i),
    .abs_o (abs_gx_w)
  );

  abs_val #(.in_width_p(in_width_p)) u_abs_gy (
    .val_i (gy_i),
    .abs_o (abs_gy_w)
  );

  // Position counters and frame threshold
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [MW-1:0] thr_q, thr_d;

  // Stage 1
  logic          s1_vld_q, s1_vld_d;
  logic [MW-1:0] s1_abs_gx_q, s1_abs_gx_d;
  logic [MW-1:0] s1_abs_gy_q, s1_abs_gy_d;
  logic [MW-1:0] s1_thr_q, s1_thr_d;
  px_flags_t     s1_flags_q, s1_flags_d;

  // Stage 2
  logic          s2_vld_q, s2_vld_d;
  logic [MW-1:0] mag_q, mag_d;
  logic          edge_q, edge_d;
  logic          eol_q, eol_d;
  logic          eof_q, eof_d;

  logic          accept_w;
  logic          s2_ready_w;
  logic          eol_w;
  logic          eof_w;
  logic          frame_start_w;
  logic          border_w;
  logic [MW-1:0] sum_w;

  assign s2_ready_w    = ~s2_vld_q | ready_i;
  assign ready_o       = ~s1_vld_q | s2_ready_w;
  assign accept_w      = valid_i & ready_o;

  assign eol_w         = (int'(col_q) == linewidth_px_p - 1);
  assign eof_w         = eol_w & (int'(row_q) == frame_height_p - 1);
  assign frame_start_w = (col_q == '0) & (row_q == '0);
  assign border_w      = (int'(row_q) < BX) | (int'(col_q) < BX);
  assign sum_w         = s1_abs_gx_q + s1_abs_gy_q;

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    thr_d       = thr_q;
    s1_vld_d    = s1_vld_q;
    s1_abs_gx_d = s1_abs_gx_q;
    s1_abs_gy_d = s1_abs_gy_q;
    s1_thr_d    = s1_thr_q;
    s1_flags_d  = s1_flags_q;
    s2_vld_d    = s2_vld_q;
    mag_d       = mag_q;
    edge_d      = edge_q;
    eol_d       = eol_q;
    eof_d       = eof_q;

    if (ready_o) begin
      s1_vld_d = valid_i;
    end

    if (accept_w) begin
      s1_abs_gx_d       = abs_gx_w;
      s1_abs_gy_d       = abs_gy_w;
      s1_flags_d.border = border_w;
      s1_flags_d.eol    = eol_w;
      s1_flags_d.eof    = eof_w;
      // Each pixel carries its own frame's threshold, so a new frame's latch
      // never leaks into the tail of the previous frame still in flight.
      s1_thr_d          = frame_start_w ? threshold_i : thr_q;
      if (frame_start_w) begin
        thr_d = threshold_i;
      end
      if (eol_w) begin
        col_d = '0;
        row_d = eof_w ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    if (s2_ready_w) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        mag_d  = s1_flags_q.border ? '0 : sum_w;
        edge_d = ~s1_flags_q.border & (sum_w >= s1_thr_q);
        eol_d  = s1_flags_q.eol;
        eof_d  = s1_flags_q.eof;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      col_q       <= '0;
      row_q       <= '0;
      thr_q       <= '1;
      s1_vld_q    <= 1'b0;
      s1_abs_gx_q <= '0;
      s1_abs_gy_q <= '0;
      s1_thr_q    <= '1;
      s1_flags_q  <= '0;
      s2_vld_q    <= 1'b0;
      mag_q       <= '0;
      edge_q      <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      thr_q       <= thr_d;
      s1_vld_q    <= s1_vld_d;
      s1_abs_gx_q <= s1_abs_gx_d;
      s1_abs_gy_q <= s1_abs_gy_d;
      s1_thr_q    <= s1_thr_d;
      s1_flags_q  <= s1_flags_d;
      s2_vld_q    <= s2_vld_d;
      mag_q       <= mag_d;
      edge_q      <= edge_d;
      eol_q       <= eol_d;
      eof_q       <= eof_d;
    end
  end

  assign valid_o = s2_vld_q;
  assign mag_o   = mag_q;
  assign edge_o  = edge_q;
  assign eol_o   = eol_q;
  assign eof_o   = eof_q;

endmodule
